// File: rtl/enc_frame_decoder.sv
// Decrypts key-XORed bytes and parses length/payload/checksum frames.
// Build option ENC_ROLLING_KEY_EN: rotate the key after every accepted byte.
module enc_frame_decoder #(
  parameter logic [7:0] KEY_RESET  = 8'hAB,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       key_load,
  input  logic [7:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_a,
  output logic [3:0] out_b,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [7:0] byte_count,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    WAIT_HDR,
    PAYLOAD,
    CHECK
  } state_t;

  state_t      state;
  logic [7:0]  key_reg;
  logic [7:0]  key_cur;
  logic [7:0]  len;
  logic [7:0]  csum;
  logic [7:0]  pt;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic        load;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign load  = key_load && (state == WAIT_HDR);

  always_comb begin
    in_ready = 1'b1;
    unique case (state)
      WAIT_HDR: in_ready = !key_load;
      PAYLOAD:  in_ready = !full;
      default:  in_ready = 1'b1;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign pt     = in_data ^ key_cur;
  assign push   = accept && (state == PAYLOAD);
  assign pop    = !empty && out_ready;

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];
  assign out_a     = out_data[7:4];
  assign out_b     = out_data[3:0];
  assign busy      = (state != WAIT_HDR);

`ifdef ENC_ROLLING_KEY_EN
  logic [7:0] key_roll;
  assign key_cur = key_roll;

  // Leaving CHECK returns to WAIT_HDR, so reload instead of rotating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_roll <= KEY_RESET;
    end else if (load) begin
      key_roll <= key_in;
    end else if (accept) begin
      if (state == CHECK) key_roll <= key_reg;
      else key_roll <= {key_roll[6:0], key_roll[7]};
    end
  end
`else
  assign key_cur = key_reg;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= pt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_HDR;
      key_reg    <= KEY_RESET;
      len        <= 8'h00;
      csum       <= 8'h00;
      byte_count <= 8'h00;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (load) key_reg <= key_in;
      if (accept) begin
        unique case (state)
          WAIT_HDR: begin
            len        <= pt;
            byte_count <= 8'h00;
            csum       <= 8'h00;
            state      <= (pt != 8'h00) ? PAYLOAD : CHECK;
          end
          PAYLOAD: begin
            csum       <= csum ^ pt;
            byte_count <= byte_count + 8'd1;
            if (byte_count + 8'd1 == len) state <= CHECK;
          end
          CHECK: begin
            frame_ok  <= (pt == csum);
            frame_err <= (pt != csum);
            state     <= WAIT_HDR;
          end
          default: state <= WAIT_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enc_frame_decoder.sv
// Scoreboard bench for enc_frame_decoder: directed frames, monitor checks.
// Build with ENC_ROLLING_KEY_EN defined to exercise the rolling key.
module tb_enc_frame_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       key_load = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] key_in = 8'h00;
  logic       in_ready;
  logic       out_valid;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;
  logic [7:0] out_data;
  logic [7:0] byte_count;
  logic [3:0] out_a;
  logic [3:0] out_b;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic       exp_v[$];
  logic [7:0] mon_e;
  logic       mon_v;

  always #5 clk = ~clk;

  enc_frame_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .key_load(key_load), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_a(out_a), .out_b(out_b),
    .frame_ok(frame_ok), .frame_err(frame_err),
    .byte_count(byte_count), .busy(busy)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("send_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_v.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("drain_timeout");
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_out_byte");
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e);
          chk("out_a", out_a, mon_e[7:4]);
          chk("out_b", out_b, mon_e[3:0]);
        end
      end
      if (frame_ok || frame_err) begin
        if (exp_v.size() == 0) begin
          fail_now("unexpected_verdict");
        end else begin
          mon_v = exp_v.pop_front();
          chk("frame_ok", frame_ok, mon_v);
          chk("frame_err", frame_err, !mon_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_a", out_a, 4'h0);
    chk("rst_out_b", out_b, 4'h0);
    chk("rst_frame_ok", frame_ok, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_byte_count", byte_count, 8'h00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

`ifdef ENC_ROLLING_KEY_EN
    exp_q.push_back(8'h00);
    exp_v.push_back(1'b1);
    send(8'hAA); send(8'h57); send(8'hAE);
    exp_q.push_back(8'h00);
    exp_v.push_back(1'b1);
    send(8'hAA); send(8'h57); send(8'hAE);
    drain();
    chk("roll_byte_count", byte_count, 8'h01);
    chk("roll_busy", busy, 1'b0);
`else
    // good frame
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_v.push_back(1'b1);
    send(8'hA9); send(8'hB9); send(8'h9F); send(8'h8D);
    drain();
    chk("f1_byte_count", byte_count, 8'h02);
    chk("f1_busy", busy, 1'b0);

    // checksum mismatch
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_v.push_back(1'b0);
    send(8'hA9); send(8'hB9); send(8'h9F); send(8'h8C);
    drain();

    // empty frame
    exp_v.push_back(1'b1);
    send(8'hAB); send(8'hAB);
    drain();
    chk("empty_byte_count", byte_count, 8'h00);

    // backpressure, N=11, payload 01..0B, checksum 00
    out_ready = 1'b0;
    for (int i = 1; i <= 11; i++) exp_q.push_back(8'(i));
    exp_v.push_back(1'b1);
    send(8'hA0);
    for (int i = 1; i <= 4; i++) send(8'(i) ^ 8'hAB);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_busy", busy, 1'b1);
    chk("bp_byte_count", byte_count, 8'h04);
    chk("bp_out_valid", out_valid, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_data", out_data, 8'h01);
      chk("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 5; i <= 11; i++) send(8'(i) ^ 8'hAB);
    send(8'hAB);
    drain();
    chk("bp_byte_count_end", byte_count, 8'h0B);

    // key load beats a simultaneous header
    @(negedge clk);
    key_load = 1'b1;
    key_in   = 8'h55;
    in_valid = 1'b1;
    in_data  = 8'h54;
    #1;
    chk("kl_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    key_load = 1'b0;
    in_valid = 1'b0;
    chk("kl_not_taken", busy, 1'b0);
    exp_q.push_back(8'h7E);
    exp_v.push_back(1'b1);
    send(8'h54); send(8'h2B); send(8'h2B);
    drain();

    // reset mid-payload discards the frame and restores the key
    out_ready = 1'b0;
    send(8'h5E); send(8'h00); send(8'h11);
    @(negedge clk);
    chk("mr_busy", busy, 1'b1);
    chk("mr_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_out_valid", out_valid, 1'b0);
    chk("mr_rst_busy", busy, 1'b0);
    chk("mr_rst_byte_count", byte_count, 8'h00);
    chk("mr_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_v.push_back(1'b1);
    send(8'hA9); send(8'hB9); send(8'h9F); send(8'h8D);
    drain();
    chk("mr_after_busy", busy, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
